// File: rtl/read_cycle.sv
// SRAM read sequencer: latches the address, toggles the SRAM clock for one high/low period, captures the data.
// Latency: reading is high for 1+2*DELAY cycles from the accepting edge; d_out updates on the final edge.
// Backpressure: none; start edges arriving while busy are dropped, not queued.
module read_cycle #(
    parameter int DELAY = 4
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       start_in,
    input  logic [8:0] a_in,
    input  logic [7:0] d_in,
    output logic       clk_out,
    output logic       cen_out,
    output logic       wen_out,
    output logic [8:0] a_out,
    output logic [7:0] d_out,
    output logic       reading
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        CLK_HI = 2'd2,
        CLK_LO = 2'd3
    } state_t;

    localparam logic [7:0] LAST = 8'(DELAY - 1);

    state_t     state;
    logic [7:0] count;
    logic       start_q;
    logic       start_edge;

    assign start_edge = start_in & ~start_q;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state   <= IDLE;
            count   <= 8'd0;
            start_q <= 1'b0;
            clk_out <= 1'b0;
            cen_out <= 1'b1;
            wen_out <= 1'b1;
            a_out   <= 9'd0;
            d_out   <= 8'd0;
            reading <= 1'b0;
        end else begin
            start_q <= start_in;
            wen_out <= 1'b1;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        a_out   <= a_in;
                        cen_out <= 1'b0;
                        reading <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    clk_out <= 1'b1;
                    count   <= 8'd0;
                    state   <= CLK_HI;
                end
                CLK_HI: begin
                    if (count == LAST) begin
                        clk_out <= 1'b0;
                        count   <= 8'd0;
                        state   <= CLK_LO;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                CLK_LO: begin
                    // Data is sampled at the end of the low phase, once the SRAM has had a full period.
                    if (count == LAST) begin
                        d_out   <= d_in;
                        cen_out <= 1'b1;
                        reading <= 1'b0;
                        count   <= 8'd0;
                        state   <= IDLE;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_read_cycle.sv
// Directed bench for read_cycle with DELAY=4 (dut) and DELAY=1 (dut1).
module tb_read_cycle;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start1 = 1'b0;
    logic [8:0] a_in = 9'd0;
    logic [7:0] d_in = 8'd0;

    logic       clk_out, cen_out, wen_out, reading;
    logic [8:0] a_out;
    logic [7:0] d_out;
    logic       clk_out1, cen_out1, wen_out1, reading1;
    logic [8:0] a_out1;
    logic [7:0] d_out1;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    read_cycle #(.DELAY(4)) dut (
        .clk_in(clk), .reset_in(rst), .start_in(start), .a_in(a_in), .d_in(d_in),
        .clk_out(clk_out), .cen_out(cen_out), .wen_out(wen_out),
        .a_out(a_out), .d_out(d_out), .reading(reading)
    );

    read_cycle #(.DELAY(1)) dut1 (
        .clk_in(clk), .reset_in(rst), .start_in(start1), .a_in(a_in), .d_in(d_in),
        .clk_out(clk_out1), .cen_out(cen_out1), .wen_out(wen_out1),
        .a_out(a_out1), .d_out(d_out1), .reading(reading1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int rd_cycles;
        int rises;
        logic prev_rd;

        // Reset for 10 cycles, then one idle cycle.
        repeat (10) step();
        rst = 1'b0;
        step();
        check("rst_clk", clk_out, 0);
        check("rst_cen", cen_out, 1);
        check("rst_wen", wen_out, 1);
        check("rst_rd", reading, 0);
        check("rst_a", a_out, 9'h000);
        check("rst_d", d_out, 8'h00);
        check("rst1_rd", reading1, 0);

        // Basic read, with a_in change and an ignored second start pulse at E0+3.
        a_in = 9'h0AB;
        d_in = 8'hCD;
        start = 1'b1;
        step();                                    // E0
        start = 1'b0;
        check("e0_a", a_out, 9'h0AB);
        check("e0_cen", cen_out, 0);
        check("e0_rd", reading, 1);
        check("e0_clk", clk_out, 0);
        check("e0_d", d_out, 8'h00);
        for (int k = 1; k <= 9; k++) begin
            if (k == 3) begin
                start = 1'b1;
                a_in  = 9'h1FF;
            end
            if (k == 4) start = 1'b0;
            step();                                // E0+k
            check($sformatf("rd_clk_%0d", k), clk_out, (k <= 4) ? 1 : 0);
            check($sformatf("rd_rd_%0d", k), reading, (k <= 8) ? 1 : 0);
            check($sformatf("rd_cen_%0d", k), cen_out, (k <= 8) ? 0 : 1);
            check($sformatf("rd_a_%0d", k), a_out, 9'h0AB);
            check($sformatf("rd_d_%0d", k), d_out, (k < 9) ? 8'h00 : 8'hCD);
            check($sformatf("rd_wen_%0d", k), wen_out, 1);
        end
        d_in = 8'h11;
        repeat (5) step();
        check("post_rd", reading, 0);
        check("post_a", a_out, 9'h0AB);
        check("post_d_hold", d_out, 8'hCD);

        // start held high for 20 cycles -> one read only.
        a_in = 9'h155;
        d_in = 8'h5A;
        start = 1'b1;
        rd_cycles = 0;
        rises = 0;
        prev_rd = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k == 20) start = 1'b0;
            step();
            if (reading) rd_cycles++;
            if (reading && !prev_rd) rises++;
            prev_rd = reading;
        end
        check("hold_rises", rises, 1);
        check("hold_cycles", rd_cycles, 9);
        check("hold_a", a_out, 9'h155);
        check("hold_d", d_out, 8'h5A);

        // Reset at E0+4 aborts; start high during reset is ignored, counts after release.
        a_in = 9'h0AB;
        d_in = 8'hCD;
        start = 1'b1;
        step();                                    // E0
        start = 1'b0;
        repeat (3) step();                         // E0+3
        check("pre_abort_clk", clk_out, 1);
        rst = 1'b1;
        start = 1'b1;
        step();                                    // E0+4
        check("abort_clk", clk_out, 0);
        check("abort_cen", cen_out, 1);
        check("abort_rd", reading, 0);
        check("abort_d", d_out, 8'h00);
        check("abort_a", a_out, 9'h000);
        step();
        check("rst_start_ign", reading, 0);
        rst = 1'b0;
        a_in = 9'h033;
        d_in = 8'h77;
        step();
        check("post_rst_start", reading, 1);
        check("post_rst_a", a_out, 9'h033);
        start = 1'b0;
        repeat (8) step();
        check("post_rst_busy", reading, 1);
        check("post_rst_d_hold", d_out, 8'h00);
        step();
        check("post_rst_done", reading, 0);
        check("post_rst_d", d_out, 8'h77);

        // DELAY=1 instance.
        a_in = 9'h0C3;
        d_in = 8'h3C;
        start1 = 1'b1;
        step();                                    // E0
        start1 = 1'b0;
        check("d1_e0_rd", reading1, 1);
        check("d1_e0_a", a_out1, 9'h0C3);
        check("d1_e0_cen", cen_out1, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("d1_clk_%0d", k), clk_out1, (k == 1) ? 1 : 0);
            check($sformatf("d1_rd_%0d", k), reading1, (k <= 2) ? 1 : 0);
            check($sformatf("d1_d_%0d", k), d_out1, (k >= 3) ? 8'h3C : 8'h00);
        end
        check("d1_other_idle", reading, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/read_cycle.md
READ_CYCLE -- requirements
Module: read_cycle

Interface
REQ-001 SHALL have parameter DELAY, default 4, number of clk_in cycles for each SRAM clock phase (high and low); legal range 1..255.
REQ-002 SHALL have clk_in  input  1  system clock (100 MHz); all logic on its rising edge.
REQ-003 SHALL have reset_in  input  1  reset, synchronous, active-high.
REQ-004 SHALL have start_in  input  1  read request; a rising edge starts one read cycle.
REQ-005 SHALL have a_in  input  9  read address from FPGA logic.
REQ-006 SHALL have d_in  input  8  read data returned by SRAM.
REQ-007 SHALL have clk_out  output  1  clock to SRAM.
REQ-008 SHALL have cen_out  output  1  SRAM chip enable, active-low.
REQ-009 SHALL have wen_out  output  1  SRAM write enable, active-low.
REQ-010 SHALL have a_out  output  9  latched address to SRAM.
REQ-011 SHALL have d_out  output  8  captured read data to FPGA logic.
REQ-012 SHALL have reading  output  1  high while a read cycle is in progress.

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 SHALL register start_in each cycle (start_q); start is detected when start_in=1 and start_q=0.
REQ-015 States SHALL be IDLE, SETUP, CLK_HI, CLK_LO.
REQ-016 In IDLE, a detected start SHALL, on that edge (E0): a_out<=a_in, cen_out<=0, reading<=1, next state SETUP.
REQ-017 In IDLE without a detected start, outputs SHALL hold; a_out and d_out keep their last values.
REQ-018 SETUP SHALL last exactly one cycle; at edge E0+1: clk_out<=1, phase counter<=0, next state CLK_HI.
REQ-019 CLK_HI SHALL hold clk_out=1 for DELAY cycles; at edge E0+1+DELAY: clk_out<=0, counter<=0, next state CLK_LO.
REQ-020 CLK_LO SHALL hold clk_out=0 for DELAY cycles; at edge E0+1+2*DELAY: d_out<=d_in, cen_out<=1, reading<=0, next state IDLE.
REQ-021 reading SHALL therefore be high for exactly 1+2*DELAY cycles; cen_out low for the same window; a_out stable throughout.
REQ-022 wen_out SHALL be constant 1; this block never writes.
REQ-023 Start edges while not in IDLE, including on the edge that returns to IDLE, SHALL be ignored and not queued.
REQ-024 start_in held high SHALL produce only one read cycle; a new one needs start_in to go low and high again.
REQ-025 a_in changes after E0 SHALL NOT affect a_out during the cycle.
REQ-026 d_out SHALL change only at the completion edge of REQ-020.

Reset
REQ-027 While reset_in=1 at a rising edge: state<=IDLE, counter<=0, start_q<=0, clk_out<=0, cen_out<=1, wen_out<=1, a_out<=0, d_out<=0, reading<=0.
REQ-028 Reset mid-cycle SHALL abort the read on that edge; no d_out capture; no start is accepted while reset_in=1.
REQ-029 If start_in is high on the first edge after reset deasserts, that SHALL count as a rising edge, because start_q=0 after reset.

Verification
REQ-030 Reset 10 cycles, then idle -> clk_out=0, cen_out=1, wen_out=1, reading=0, a_out=0x000, d_out=0x00.
REQ-031 DELAY=4, a_in=0x0AB, d_in=0xCD, 1-cycle start pulse at E0 -> a_out=0x0AB and cen_out=0 from E0; clk_out high E0+1..E0+5; reading high 9 cycles; d_out=0xCD at E0+9.
REQ-032 start_in held high 20 cycles -> exactly one read cycle.
REQ-033 Second start pulse at E0+3 with a_in=0x1FF -> ignored; a_out stays 0x0AB.
REQ-034 reset_in=1 at E0+4 -> clk_out=0, cen_out=1, reading=0, d_out=0x00 next cycle.
REQ-035 DELAY=1 -> reading high 3 cycles, clk_out high 1 cycle, d_out captured at E0+3.
